// File: rtl/weight_mem_writer_if.sv
// Serial weight load handshake between the loader and weight_mem_writer.
// Signals: start, in_valid, in_bit (loader to writer), in_ready (writer to loader).
interface weight_mem_writer_if;
    logic start;
    logic in_valid;
    logic in_bit;
    logic in_ready;

    modport master (
        output start,
        output in_valid,
        output in_bit,
        input  in_ready
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_bit,
        output in_ready
    );
endinterface

// File: rtl/weight_mem_writer.sv
// Loads N signed 8-bit weights from an MSB-first serial bit stream into an
// internal array and exposes them on a combinational read port.
// Ports: clk, rst_n (async, active-low); ld (slave: start, in_valid, in_bit,
// in_ready); Adr/out read port; done; wr_count; checksum when
// WMW_CHECKSUM_EN is defined (sum of written weights, sign-extended, mod 2^16).
module weight_mem_writer #(
    parameter int N = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    weight_mem_writer_if.slave  ld,
    input  logic [31:0]         Adr,
    output logic signed [7:0]   out,
    output logic                done,
    output logic [31:0]         wr_count
`ifdef WMW_CHECKSUM_EN
    ,
    output logic [15:0]         checksum
`endif
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [6:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_adr_q, wr_adr_d;
    logic [31:0]     wr_count_q, wr_count_d;
    logic [7:0]      mem_q [N];
    logic            we;
    logic [7:0]      wdata;
    logic            init;

`ifdef WMW_CHECKSUM_EN
    logic [15:0]     checksum_q, checksum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wr_adr_q   <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_adr_q   <= wr_adr_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_adr_d    = wr_adr_q;
        wr_count_d  = wr_count_q;
        we          = 1'b0;
        wdata       = {shift_q, ld.in_bit};
        init        = 1'b0;
        ld.in_ready = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ld.start) begin
                    init = 1'b1;
                end
            end
            LOAD: begin
                ld.in_ready = 1'b1;
                if (ld.in_valid) begin
                    if (bit_cnt_q == 3'd7) begin
                        we         = 1'b1;
                        bit_cnt_d  = '0;
                        wr_count_d = wr_count_q + 32'd1;
                        if (wr_adr_q == AW'(N - 1)) begin
                            state_d = DONE;
                        end else begin
                            wr_adr_d = wr_adr_q + AW'(1);
                        end
                    end else begin
                        shift_d   = {shift_q[5:0], ld.in_bit};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (ld.start) begin
                    init = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Honoured start: fresh load, stale partial byte discarded.
        if (init) begin
            state_d    = LOAD;
            bit_cnt_d  = '0;
            shift_d    = '0;
            wr_adr_d   = '0;
            wr_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < N; i++) begin
                if (wr_adr_q == AW'(i)) begin
                    mem_q[i] <= wdata;
                end
            end
        end
    end

    // Full-width compare so out-of-range addresses read as zero.
    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            if (Adr == 32'(i)) begin
                out = mem_q[i];
            end
        end
    end

    assign wr_count = wr_count_q;

`ifdef WMW_CHECKSUM_EN
    always_comb begin
        checksum_d = checksum_q;
        if (init) begin
            checksum_d = '0;
        end else if (we) begin
            checksum_d = checksum_q + {{8{wdata[7]}}, wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_mem_writer.sv
// Scoreboard bench for weight_mem_writer, N=4.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_weight_mem_writer;
    localparam int N = 4;

    localparam int K_OUT = 0;
    localparam int K_DONE = 1;
    localparam int K_CNT = 2;
    localparam int K_RDY = 3;
    localparam int K_CSUM = 4;

    logic               clk;
    logic               rst_n;
    logic [31:0]        adr;
    logic signed [7:0]  rd;
    logic               done;
    logic [31:0]        wr_count;
`ifdef WMW_CHECKSUM_EN
    logic [15:0]        checksum;
`endif

    weight_mem_writer_if ld ();

    weight_mem_writer #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld.slave),
        .Adr      (adr),
        .out      (rd),
        .done     (done),
        .wr_count (wr_count)
`ifdef WMW_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       nm;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad = 0;

    initial begin
        item_t       it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                case (it.kind)
                    K_OUT:  act = {24'h0, rd};
                    K_DONE: act = {31'h0, done};
                    K_CNT:  act = wr_count;
                    K_RDY:  act = {31'h0, ld.in_ready};
`ifdef WMW_CHECKSUM_EN
                    K_CSUM: act = {16'h0, checksum};
`endif
                    default: act = 'x;
                endcase
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h want %0h",
                             it.nm, act, it.exp);
                end
            end
        end
    end

    task automatic chk(input int kind, input logic [31:0] a,
                       input logic [31:0] e, input string nm);
        item_t it;
        ld.in_valid = 1'b0;
        adr = a;
        it.kind = kind;
        it.exp = e;
        it.nm = nm;
        sb.push_back(it);
        for (int k = 0; k < 3 && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            $display("FAIL %s: monitor timeout", nm);
            $fatal(1, "scoreboard stuck");
        end
    endtask

    task automatic send_bit(input logic b);
        ld.in_valid = 1'b1;
        ld.in_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic do_start();
        ld.in_valid = 1'b0;
        ld.start = 1'b1;
        @(posedge clk);
        #1;
        ld.start = 1'b0;
    endtask

    task automatic idle(input int n);
        ld.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ld.start = 1'b0;
        ld.in_valid = 1'b0;
        ld.in_bit = 1'b0;
        adr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bits offered with no start are ignored.
        for (int i = 0; i < 6; i++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        chk(K_RDY, 0, 0, "idle_rdy");
        chk(K_DONE, 0, 0, "idle_done");
        chk(K_CNT, 0, 0, "idle_cnt");
        for (int a = 0; a < N; a++) begin
            chk(K_OUT, a, 0, "idle_out");
        end
        chk(K_OUT, 7, 0, "idle_out7");

        // Full load: 3, -1, -128, 127.
        do_start();
        send_byte(8'h03);
        send_byte(8'hFF);
        send_byte(8'h80);
        for (int i = 6; i >= 0; i--) begin
            send_bit(1'(8'h7F >> (i + 1)));
        end
        chk(K_DONE, 0, 0, "done_b31");
        chk(K_CNT, 0, 3, "cnt_b31");
        send_bit(1'b1);
        chk(K_DONE, 0, 1, "done_b32");
        chk(K_CNT, 0, 4, "cnt_full");
        chk(K_RDY, 0, 0, "rdy_done");
        chk(K_OUT, 0, 32'h03, "full_a0");
        chk(K_OUT, 1, 32'hFF, "full_a1");
        chk(K_OUT, 2, 32'h80, "full_a2");
        chk(K_OUT, 3, 32'h7F, "full_a3");
        chk(K_OUT, 4, 0, "full_a4");
`ifdef WMW_CHECKSUM_EN
        chk(K_CSUM, 0, 32'h0001, "csum");
`endif
        // DONE refuses further bits.
        send_byte(8'h55);
        chk(K_OUT, 0, 32'h03, "done_hold_a0");
        chk(K_CNT, 0, 4, "done_hold_cnt");

        // Reload overwrites entry 0 only.
        do_start();
        chk(K_DONE, 0, 0, "rl_done0");
        chk(K_CNT, 0, 0, "rl_cnt0");
        send_byte(8'h01);
        chk(K_OUT, 0, 32'h01, "rl_a0");
        chk(K_OUT, 1, 32'hFF, "rl_a1");
        chk(K_OUT, 2, 32'h80, "rl_a2");
        chk(K_OUT, 3, 32'h7F, "rl_a3");
        chk(K_DONE, 0, 0, "rl_done");
        chk(K_CNT, 0, 1, "rl_cnt");

        // Stall mid-byte; a start here must be ignored.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        chk(K_RDY, 0, 1, "stall_rdy");
        idle(2);
        ld.start = 1'b1;
        idle(1);
        ld.start = 1'b0;
        idle(2);
        chk(K_CNT, 0, 1, "stall_cnt");
        chk(K_DONE, 0, 0, "stall_done");
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk(K_OUT, 1, 32'h03, "stall_a1");
        chk(K_OUT, 0, 32'h01, "stall_a0");
        chk(K_CNT, 0, 2, "stall_cnt2");

        // Reset after 12 more bits clears everything.
        send_byte(8'hAA);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        for (int a = 0; a < N; a++) begin
            chk(K_OUT, a, 0, "rst_out");
        end
        chk(K_RDY, 0, 0, "rst_rdy");
        chk(K_CNT, 0, 0, "rst_cnt");
        rst_n = 1'b1;
        idle(1);
        do_start();
        send_byte(8'h05);
        chk(K_OUT, 0, 32'h05, "post_rst_a0");
        chk(K_OUT, 1, 0, "post_rst_a1");
        chk(K_CNT, 0, 1, "post_rst_cnt");

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
